control_fsm: RTL and testbench
==============================

# control_fsm

Main control state machine for the multicycle RV32I core. It sequences every instruction through fetch, decode, execute, memory and writeback states, and it drives the datapath multiplexer selects and write enables. It sits between the instruction register (opcode source) and the datapath. The ALU decoder consumes `o_ALUOp`. PC-write logic outside this block combines `o_PCUpdate`, `o_Branch` and the ALU zero flag.

## Interface
Parameters: none.
- `i_clk` input 1: clock; all state changes occur on the rising edge.
- `i_rstn` input 1: reset, synchronous, active-high. When 1 at a rising edge, the state becomes FETCH.
- `i_zero` input 1: ALU zero flag. It is accepted but has no effect on state or outputs; branch resolution happens outside this block.
- `i_opcode` input 7: opcode field from the instruction register, `instr[6:0]`.
- `o_RegWrite` output 1: register file write enable.
- `o_MemWrite` output 1: data memory write enable.
- `o_IRWrite` output 1: instruction register load enable.
- `o_AdSrc` output 1: memory address select. 0 = PC, 1 = ALU result register.
- `o_PCUpdate` output 1: unconditional PC write.
- `o_Branch` output 1: branch state flag.
- `o_ResultSrc` output 2: result mux select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `o_ALUSrcA` output 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1 data.
- `o_ALUSrcB` output 2: ALU B select. 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `o_ALUOp` output 2: ALU operation class. 00 = add, 01 = subtract (branch), 10 = decode funct fields.

## Operation
- Moore machine. All outputs are decoded from the current state only.
- Any output not listed for a state is 0.
- States and their nonzero outputs:
  - FETCH: IRWrite=1, AdSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - ALUWB: ResultSrc=00, RegWrite=1.
- Transitions:
  - FETCH→DECODE, unconditionally.
  - DECODE dispatches on `i_opcode`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECUTER
    - 0010011 (I-type ALU) → EXECUTEI
    - 1101111 (jal) → JAL
    - 1100011 (beq) → BEQ
    - any other value → FETCH (illegal opcode is dropped, no side effects)
  - MEMADR: 0000011 → MEMREAD; 0100011 → MEMWRITE; any other value → FETCH.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER, EXECUTEI and JAL → ALUWB; ALUWB→FETCH.
  - BEQ→FETCH.
- State encoding is free (4-bit binary recommended). Unused encodings go to FETCH on the next edge and drive all-zero outputs.

## Timing
- After reset is released, the first cycle is FETCH with outputs IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10, all others 0.
- Reset values of the outputs are therefore those FETCH values.
- Reset has priority over every transition. Asserting it in any state gives FETCH on the next edge.
- `i_opcode` is sampled at the rising edge that leaves DECODE, and again at the edge that leaves MEMADR. It must remain stable from DECODE through MEMADR.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.

## Test plan
- Reset: `i_rstn`=1 for 2 edges, then 0. During and immediately after reset, outputs equal the FETCH values: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10, RegWrite=MemWrite=0.
- lw, opcode 0000011 held: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. Check AdSrc=1 in MEMREAD, then ResultSrc=01 with RegWrite=1 in MEMWB.
- sw, opcode 0100011: FETCH, DECODE, MEMADR, MEMWRITE, FETCH. MemWrite=1 and AdSrc=1 for exactly 1 cycle.
- R-type 0110011, then I-type 0010011, then jal 1101111:
  - R and I each reach ALUWB in 4 cycles with ALUOp=10 in the execute state and RegWrite=1 in ALUWB.
  - jal shows PCUpdate=1, ALUSrcA=01, ALUSrcB=10 in the JAL state.
- beq, opcode 1100011: FETCH, DECODE, BEQ, FETCH. BEQ state drives Branch=1, ALUOp=01, ALUSrcA=10, ALUSrcB=00, for both `i_zero`=0 and `i_zero`=1.
- Illegal opcode 0001010: DECODE returns to FETCH, with RegWrite and MemWrite never asserted. Asserting reset mid-lw (in MEMREAD) gives FETCH on the next edge.

Source files
------------

// File: rtl/control_fsm.sv
// Main control FSM of the multicycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and enables.
module control_fsm (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_zero,
    input  logic [6:0] i_opcode,
    output logic       o_RegWrite,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_AdSrc,
    output logic       o_PCUpdate,
    output logic       o_Branch,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ALUOp
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_BEQ      = 4'd9,
        S_ALUWB    = 4'd10
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic       ad_src;
        logic       pc_update;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam ctrl_t      CTRL_IDLE = 14'b0;

    state_t state_r;
    ctrl_t  ctrl_r;

    // The zero flag is consumed by the external PC-write logic, not here.
    logic unused_zero_s;
    assign unused_zero_s = i_zero;

    function automatic state_t next_state_f(input state_t state, input logic [6:0] opcode);
        next_state_f = S_FETCH;
        case (state)
            S_FETCH:    next_state_f = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state_f = S_MEMADR;
                    OP_R:         next_state_f = S_EXECUTER;
                    OP_I:         next_state_f = S_EXECUTEI;
                    OP_JAL:       next_state_f = S_JAL;
                    OP_BEQ:       next_state_f = S_BEQ;
                    default:      next_state_f = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (opcode)
                    OP_LW:   next_state_f = S_MEMREAD;
                    OP_SW:   next_state_f = S_MEMWRITE;
                    default: next_state_f = S_FETCH;
                endcase
            end
            S_MEMREAD:  next_state_f = S_MEMWB;
            S_MEMWB:    next_state_f = S_FETCH;
            S_MEMWRITE: next_state_f = S_FETCH;
            S_EXECUTER: next_state_f = S_ALUWB;
            S_EXECUTEI: next_state_f = S_ALUWB;
            S_JAL:      next_state_f = S_ALUWB;
            S_BEQ:      next_state_f = S_FETCH;
            S_ALUWB:    next_state_f = S_FETCH;
            default:    next_state_f = S_FETCH;
        endcase
    endfunction

    // Moore output table; unused encodings fall through to all-zero.
    function automatic ctrl_t decode_ctrl_f(input state_t state);
        ctrl_t c;
        c = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: c.ad_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.ad_src    = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_ALUWB: c.reg_write = 1'b1;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    // State register; outputs are registered by decoding the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            state_r <= S_FETCH;
            ctrl_r  <= decode_ctrl_f(S_FETCH);
        end else begin
            state_r <= next_state_f(state_r, i_opcode);
            ctrl_r  <= decode_ctrl_f(next_state_f(state_r, i_opcode));
        end
    end

    assign o_RegWrite  = ctrl_r.reg_write;
    assign o_MemWrite  = ctrl_r.mem_write;
    assign o_IRWrite   = ctrl_r.ir_write;
    assign o_AdSrc     = ctrl_r.ad_src;
    assign o_PCUpdate  = ctrl_r.pc_update;
    assign o_Branch    = ctrl_r.branch;
    assign o_ResultSrc = ctrl_r.result_src;
    assign o_ALUSrcA   = ctrl_r.alu_src_a;
    assign o_ALUSrcB   = ctrl_r.alu_src_b;
    assign o_ALUOp     = ctrl_r.alu_op;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: the driver queues the hand-computed output
// vector expected after each edge, and a monitor pops and compares after every edge.
module tb_control_fsm;

    logic       clk;
    logic       rst;
    logic       zero;
    logic [6:0] opcode;
    logic       reg_write, mem_write, ir_write, ad_src, pc_update, branch;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [13:0] vec;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    // {RegWrite,MemWrite,IRWrite,AdSrc,PCUpdate,Branch,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    localparam logic [13:0] V_FETCH    = 14'b0_0_1_0_1_0_10_00_10_00;
    localparam logic [13:0] V_DECODE   = 14'b0_0_0_0_0_0_00_01_01_00;
    localparam logic [13:0] V_MEMADR   = 14'b0_0_0_0_0_0_00_10_01_00;
    localparam logic [13:0] V_MEMREAD  = 14'b0_0_0_1_0_0_00_00_00_00;
    localparam logic [13:0] V_MEMWB    = 14'b1_0_0_0_0_0_01_00_00_00;
    localparam logic [13:0] V_MEMWRITE = 14'b0_1_0_1_0_0_00_00_00_00;
    localparam logic [13:0] V_EXECR    = 14'b0_0_0_0_0_0_00_10_00_10;
    localparam logic [13:0] V_EXECI    = 14'b0_0_0_0_0_0_00_10_01_10;
    localparam logic [13:0] V_JAL      = 14'b0_0_0_0_1_0_00_01_10_00;
    localparam logic [13:0] V_BEQ      = 14'b0_0_0_0_0_1_00_10_00_01;
    localparam logic [13:0] V_ALUWB    = 14'b1_0_0_0_0_0_00_00_00_00;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b0001010;

    control_fsm dut (
        .i_clk       (clk),
        .i_rstn      (rst),
        .i_zero      (zero),
        .i_opcode    (opcode),
        .o_RegWrite  (reg_write),
        .o_MemWrite  (mem_write),
        .o_IRWrite   (ir_write),
        .o_AdSrc     (ad_src),
        .o_PCUpdate  (pc_update),
        .o_Branch    (branch),
        .o_ResultSrc (result_src),
        .o_ALUSrcA   (alu_src_a),
        .o_ALUSrcB   (alu_src_b),
        .o_ALUOp     (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for the coming edge and queue the outputs expected after it.
    task automatic cyc(input logic r, input logic [6:0] op, input logic z,
                       input logic [13:0] vec, input string name);
        exp_t e;
        rst    = r;
        opcode = op;
        zero   = z;
        e.vec  = vec;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge presents a new Moore output vector.
    initial begin
        logic [13:0] act;
        exp_t        e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {reg_write, mem_write, ir_write, ad_src, pc_update, branch,
                       result_src, alu_src_a, alu_src_b, alu_op};
                compared++;
                if (act !== e.vec) begin
                    mismatched++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.vec);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = 7'b0; zero = 1'b0;
        cyc(1'b1, OP_ILL, 1'b0, V_FETCH, "reset_edge1");
        cyc(1'b1, OP_ILL, 1'b0, V_FETCH, "reset_edge2");

        cyc(1'b0, OP_LW, 1'b0, V_DECODE,  "lw_decode");
        cyc(1'b0, OP_LW, 1'b0, V_MEMADR,  "lw_memadr");
        cyc(1'b0, OP_LW, 1'b0, V_MEMREAD, "lw_memread");
        cyc(1'b0, OP_LW, 1'b0, V_MEMWB,   "lw_memwb");
        cyc(1'b0, OP_LW, 1'b0, V_FETCH,   "lw_fetch");

        cyc(1'b0, OP_SW, 1'b0, V_DECODE,   "sw_decode");
        cyc(1'b0, OP_SW, 1'b0, V_MEMADR,   "sw_memadr");
        cyc(1'b0, OP_SW, 1'b0, V_MEMWRITE, "sw_memwrite");
        cyc(1'b0, OP_SW, 1'b0, V_FETCH,    "sw_fetch");

        cyc(1'b0, OP_R, 1'b0, V_DECODE, "r_decode");
        cyc(1'b0, OP_R, 1'b0, V_EXECR,  "r_execute");
        cyc(1'b0, OP_R, 1'b0, V_ALUWB,  "r_aluwb");
        cyc(1'b0, OP_R, 1'b0, V_FETCH,  "r_fetch");

        cyc(1'b0, OP_I, 1'b0, V_DECODE, "i_decode");
        cyc(1'b0, OP_I, 1'b0, V_EXECI,  "i_execute");
        cyc(1'b0, OP_I, 1'b0, V_ALUWB,  "i_aluwb");
        cyc(1'b0, OP_I, 1'b0, V_FETCH,  "i_fetch");

        cyc(1'b0, OP_JAL, 1'b0, V_DECODE, "jal_decode");
        cyc(1'b0, OP_JAL, 1'b0, V_JAL,    "jal_state");
        cyc(1'b0, OP_JAL, 1'b0, V_ALUWB,  "jal_aluwb");
        cyc(1'b0, OP_JAL, 1'b0, V_FETCH,  "jal_fetch");

        cyc(1'b0, OP_BEQ, 1'b0, V_DECODE, "beq_z0_decode");
        cyc(1'b0, OP_BEQ, 1'b0, V_BEQ,    "beq_z0_state");
        cyc(1'b0, OP_BEQ, 1'b0, V_FETCH,  "beq_z0_fetch");
        cyc(1'b0, OP_BEQ, 1'b1, V_DECODE, "beq_z1_decode");
        cyc(1'b0, OP_BEQ, 1'b1, V_BEQ,    "beq_z1_state");
        cyc(1'b0, OP_BEQ, 1'b1, V_FETCH,  "beq_z1_fetch");

        cyc(1'b0, OP_ILL, 1'b0, V_DECODE, "ill_decode");
        cyc(1'b0, OP_ILL, 1'b0, V_FETCH,  "ill_fetch");

        // Opcode changing to an unknown value while in MEMADR drops the access.
        cyc(1'b0, OP_LW,  1'b0, V_DECODE, "memadr_ill_decode");
        cyc(1'b0, OP_LW,  1'b0, V_MEMADR, "memadr_ill_memadr");
        cyc(1'b0, OP_ILL, 1'b0, V_FETCH,  "memadr_ill_fetch");

        cyc(1'b0, OP_LW, 1'b0, V_DECODE,  "rstmid_decode");
        cyc(1'b0, OP_LW, 1'b0, V_MEMADR,  "rstmid_memadr");
        cyc(1'b0, OP_LW, 1'b0, V_MEMREAD, "rstmid_memread");
        cyc(1'b1, OP_LW, 1'b0, V_FETCH,   "rstmid_fetch");
        cyc(1'b0, OP_LW, 1'b0, V_DECODE,  "rstmid_restart_decode");
        cyc(1'b0, OP_ILL, 1'b0, V_FETCH,  "rstmid_restart_fetch");

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
